// File: rtl/cnn_window_gen_if.sv
// cnn_window_gen_if: pixel-stream in / window-stream out bundle for cnn_window_gen.
//   i_in_valid, i_sof, i_pixel      : raster pixel stream into the window generator
//   o_ot_valid, o_window, o_frame_done : KXxKY window stream to the convolution consumer
// Modports: master = stream producer / window consumer, slave = window generator.
interface cnn_window_gen_if #(
  parameter int unsigned I_F_BW = 8,
  parameter int unsigned KX     = 5,
  parameter int unsigned KY     = 5
);
  logic                       i_in_valid;
  logic                       i_sof;
  logic [I_F_BW-1:0]          i_pixel;
  logic                       o_ot_valid;
  logic [KX*KY*I_F_BW-1:0]    o_window;
  logic                       o_frame_done;

  modport master (
    output i_in_valid, i_sof, i_pixel,
    input  o_ot_valid, o_window, o_frame_done
  );

  modport slave (
    input  i_in_valid, i_sof, i_pixel,
    output o_ot_valid, o_window, o_frame_done
  );
endinterface

// File: rtl/cnn_window_gen.sv
// cnn_window_gen: sliding KXxKY window generator for a raster pixel stream.
// Ports:
//   clk   : single rising-edge clock
//   reset : asynchronous active-high reset (aborts the current frame)
//   bus   : cnn_window_gen_if.slave (pixel stream in, window stream out)
// Window element (r,c) is at o_window[(r*KX+c)*I_F_BW +: I_F_BW], r=0 oldest row,
// c=0 oldest column. KY-1 line buffers feed the upper rows of each new column.
// Optional build macro CNN_WIN_STRIDE2_EN: only flag windows at even row/col
// offsets from the first valid window (stride 2); frame-done timing is unchanged.
module cnn_window_gen #(
  parameter int unsigned I_F_BW = 8,
  parameter int unsigned KX     = 5,
  parameter int unsigned KY     = 5,
  parameter int unsigned IMG_W  = 28,
  parameter int unsigned IMG_H  = 28
) (
  input  logic             clk,
  input  logic             reset,
  cnn_window_gen_if.slave  bus
);

  localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned NB = KY - 1;
  localparam int unsigned WB = KX * KY * I_F_BW;

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [CW-1:0]     pos_col;
  logic [RW-1:0]     pos_row;
  logic              accept;
  logic              win_hit;
  logic              last_pix;
  logic              stride_ok;
  logic              ot_valid;
  logic              frame_done;
  logic [WB-1:0]     window_flat;

  logic [I_F_BW-1:0] lb     [NB][IMG_W];
  logic [I_F_BW-1:0] win    [KY][KX];
  logic [I_F_BW-1:0] col_in [KY];

  assign accept = bus.i_in_valid;

  // Position of the pixel being accepted; i_sof forces (0,0) to resync.
  always_comb begin
    pos_col = bus.i_sof ? '0 : col;
    pos_row = bus.i_sof ? '0 : row;
  end

`ifdef CNN_WIN_STRIDE2_EN
  localparam logic ROW_PAR = 1'((KY - 1) % 2);
  localparam logic COL_PAR = 1'((KX - 1) % 2);
  assign stride_ok = (pos_row[0] == ROW_PAR) && (pos_col[0] == COL_PAR);
`else
  assign stride_ok = 1'b1;
`endif

  // Full window only once KY rows and KX columns of this row are in; this also
  // masks row-wrap straddles and stale line-buffer data from an earlier frame.
  always_comb begin
    win_hit  = (pos_row >= RW'(KY - 1)) && (pos_col >= CW'(KX - 1)) && stride_ok;
    last_pix = (pos_row == RW'(IMG_H - 1)) && (pos_col == CW'(IMG_W - 1));
  end

  // New column: line buffers oldest-first on top, live pixel at the bottom.
  always_comb begin
    for (int unsigned r = 0; r < NB; r++) begin
      col_in[r] = lb[r][pos_col];
    end
    col_in[KY-1] = bus.i_pixel;
  end

  // Line buffers need no reset: their contents are masked until refilled.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned r = 0; r < NB; r++) begin
        lb[r][pos_col] <= col_in[r+1];
      end
    end
  end

  // Window shift register, position counters and output strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned r = 0; r < KY; r++) begin
        for (int unsigned c = 0; c < KX; c++) begin
          win[r][c] <= '0;
        end
      end
      col        <= '0;
      row        <= '0;
      ot_valid   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      ot_valid   <= accept && win_hit;
      frame_done <= accept && last_pix;
      if (accept) begin
        for (int unsigned r = 0; r < KY; r++) begin
          for (int unsigned c = 0; c + 1 < KX; c++) begin
            win[r][c] <= win[r][c+1];
          end
          win[r][KX-1] <= col_in[r];
        end
        if (pos_col == CW'(IMG_W - 1)) begin
          col <= '0;
          row <= (pos_row == RW'(IMG_H - 1)) ? '0 : pos_row + RW'(1);
        end else begin
          col <= pos_col + CW'(1);
          row <= pos_row;
        end
      end
    end
  end

  // Flatten the window registers onto the output bus.
  always_comb begin
    window_flat = '0;
    for (int unsigned r = 0; r < KY; r++) begin
      for (int unsigned c = 0; c < KX; c++) begin
        window_flat[(r*KX+c)*I_F_BW +: I_F_BW] = win[r][c];
      end
    end
  end

  assign bus.o_ot_valid   = ot_valid;
  assign bus.o_frame_done = frame_done;
  assign bus.o_window     = window_flat;

endmodule

// File: doc/cnn_window_gen.md
CNN_WINDOW_GEN -- requirements
Module: cnn_window_gen

Interface
REQ-001 The block SHALL have parameter I_F_BW, default 8, bits per input pixel.
REQ-002 The block SHALL have parameter KX, default 5, window width in pixels.
REQ-003 The block SHALL have parameter KY, default 5, window height in rows.
REQ-004 The block SHALL have parameter IMG_W, default 28, image width in pixels (KX <= IMG_W <= 1024).
REQ-005 The block SHALL have parameter IMG_H, default 28, image height in rows (KY <= IMG_H <= 1024).
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge triggered.
REQ-007 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-008 The block SHALL have port i_in_valid, input, 1 bit, pixel strobe; i_pixel is accepted on every rising clk edge where it is high.
REQ-009 The block SHALL have port i_sof, input, 1 bit, start of frame; it is qualified by i_in_valid and marks the accepted pixel as (row 0, col 0).
REQ-010 The block SHALL have port i_pixel, input, I_F_BW bits, unsigned pixel in raster order.
REQ-011 The block SHALL have port o_ot_valid, output, 1 bit, one-cycle strobe marking o_window valid.
REQ-012 The block SHALL have port o_window, output, KX*KY*I_F_BW bits, packed KXxKY window for the convolution consumer.
REQ-013 The block SHALL have port o_frame_done, output, 1 bit, one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-014 The block SHALL hold KY-1 line buffers of IMG_W entries each, plus a KYxKX shift-register window.
REQ-015 On each accepted pixel the block SHALL shift the window left by one column and load a new rightmost column: line buffers oldest to newest in rows 0..KY-2, i_pixel in row KY-1.
REQ-016 On each accepted pixel the block SHALL push the column into the line buffers at the current column index, so each buffer is delayed one row from the next.
REQ-017 Window element (r,c) SHALL sit at o_window[(r*KX+c)*I_F_BW +: I_F_BW], with r=0 the oldest row and c=0 the oldest column.
REQ-018 The block SHALL keep col (0..IMG_W-1) and row (0..IMG_H-1) counters of the accepted pixel; col wraps to 0 and row increments at IMG_W-1; both wrap to 0 after (IMG_H-1, IMG_W-1).
REQ-019 On i_in_valid&i_sof the accepted pixel SHALL be at (0,0) whatever the counter state, and counting SHALL continue from there (resync).
REQ-020 o_ot_valid SHALL be asserted exactly one cycle after accepting a pixel at row>=KY-1 and col>=KX-1; o_window SHALL update in that same cycle.
REQ-021 Per frame the block SHALL emit exactly (IMG_H-KY+1)*(IMG_W-KX+1) windows, i.e. 576 at the defaults.
REQ-022 When i_in_valid is low, the window, line buffers and counters SHALL hold; o_ot_valid SHALL be 0 and o_window SHALL hold its value.
REQ-023 A window that straddles the row wrap (col<KX-1) SHALL never be flagged valid; stale line-buffer contents from the previous frame SHALL never appear in a valid window for row<KY-1.
REQ-024 o_frame_done SHALL pulse one cycle after accepting pixel (IMG_H-1, IMG_W-1), coincident with the final o_ot_valid.
REQ-025 The block SHALL have no backpressure; the consumer accepts every o_ot_valid, with back-to-back strobes allowed.

Reset
REQ-026 While reset is high, the block SHALL force o_ot_valid=0, o_frame_done=0, o_window=0, row=0 and col=0.
REQ-027 Line-buffer storage SHALL NOT need a reset, because it is masked by REQ-023.
REQ-028 Reset asserted mid-frame SHALL abort the frame; the next accepted pixel SHALL be treated as (0,0).

Configuration
REQ-029 With macro CNN_WIN_STRIDE2_EN defined, o_ot_valid SHALL additionally require (row-(KY-1)) and (col-(KX-1)) both even, giving 144 windows per frame at the defaults, with o_frame_done unchanged.
REQ-030 Without CNN_WIN_STRIDE2_EN, the block SHALL use stride 1 as in REQ-020.

Verification
REQ-031 Reset, then stream one 28x28 frame with pixel=(row*28+col) mod 256 and continuous valid -> the first o_ot_valid comes 1 cycle after pixel (4,4), with element (0,0)=0 and element (4,4)=116; the bench counts 576 strobes and 1 o_frame_done.
REQ-032 Same frame with i_in_valid toggled randomly at 50% -> an identical window sequence, with o_window holding during gaps.
REQ-033 Two frames back-to-back, frame 2 = frame 1 + 1 -> no valid strobe during frame-2 rows 0..3; frame-2 first window element (0,0)=1.
REQ-034 Assert i_sof at pixel 100 of a frame -> counters resync; next first window after 4 rows + 4 pixels with correct contents.
REQ-035 Assert reset at pixel 300 for 2 cycles, then a fresh frame -> outputs 0 during reset; 576 correct windows follow.
REQ-036 With CNN_WIN_STRIDE2_EN defined, stream the REQ-031 frame -> 144 strobes at even offsets; second strobe element (0,0)=2.
